byte_packer: RTL and testbench

- Width-converting stage that consumes a byte stream on an 8-bit valid/ready interface and emits packed words of BEATS bytes on a wider valid/ready interface.
- Sits directly downstream of the 8-bit register-slice stage and takes its down_* outputs as its up_* inputs.
- Sustains one byte accepted per cycle with no bubbles when the downstream is always ready.

---
 rtl/byte_packer.sv | 129 ++++++++++++
 tb/tb_byte_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// Byte-to-word packer: gathers BEATS bytes from an 8-bit valid/ready stream into one wide word.
// Optional BYTE_PACKER_FLUSH_EN adds up_last/down_keep for short, zero-padded final words.
module byte_packer #(
    parameter  int BEATS = 4,
    localparam int OUT_W = 8 * BEATS,
    localparam int CNT_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       up_data,
    input  logic             up_valid,
`ifdef BYTE_PACKER_FLUSH_EN
    input  logic             up_last,
`endif
    output logic             up_ready,
    output logic [OUT_W-1:0] down_data,
    output logic             down_valid,
`ifdef BYTE_PACKER_FLUSH_EN
    output logic [BEATS-1:0] down_keep,
`endif
    input  logic             down_ready
);

    logic [BEATS-2:0][7:0] acc_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [OUT_W-1:0]      out_reg_r;
    logic                  out_vld_r;

    logic                  final_s;
    logic                  accept_s;
    logic                  load_s;
    logic [OUT_W-1:0]      acc_ext_s;
    logic [OUT_W-1:0]      word_s;

    // Final-beat detection and handshake; only the word-closing beat can be stalled by the output.
    always_comb begin
        final_s  = 1'b0;
        up_ready = 1'b1;
        accept_s = 1'b0;
        load_s   = 1'b0;
`ifdef BYTE_PACKER_FLUSH_EN
        final_s  = (cnt_r == CNT_W'(BEATS - 1)) || up_last;
`else
        final_s  = (cnt_r == CNT_W'(BEATS - 1));
`endif
        up_ready = !final_s || !out_vld_r || down_ready;
        accept_s = up_valid && up_ready;
        load_s   = accept_s && final_s;
    end

    // Assemble the outgoing word: stored bytes below cnt, the live byte at cnt, zeros above.
    always_comb begin
        acc_ext_s = {8'h00, acc_r};
        word_s    = {OUT_W{1'b0}};
        for (int k = 0; k < BEATS; k++) begin
            if (k < int'(cnt_r)) begin
                word_s[8*k +: 8] = acc_ext_s[8*k +: 8];
            end else if (k == int'(cnt_r)) begin
                word_s[8*k +: 8] = up_data;
            end else begin
                word_s[8*k +: 8] = 8'h00;
            end
        end
    end

    // Beat counter and byte accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            acc_r <= {(BEATS-1){8'h00}};
        end else if (accept_s) begin
            if (final_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            for (int k = 0; k < BEATS - 1; k++) begin
                if (!final_s && (cnt_r == CNT_W'(k))) begin
                    acc_r[k] <= up_data;
                end
            end
        end
    end

    // Output register: a new word load takes priority over the drain clearing valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg_r <= {OUT_W{1'b0}};
            out_vld_r <= 1'b0;
        end else if (load_s) begin
            out_reg_r <= word_s;
            out_vld_r <= 1'b1;
        end else if (down_ready) begin
            out_vld_r <= 1'b0;
        end
    end

`ifdef BYTE_PACKER_FLUSH_EN
    logic [BEATS-1:0] keep_s;
    logic [BEATS-1:0] keep_r;

    // Byte-enable mask for the word being loaded: one bit per received byte.
    always_comb begin
        keep_s = {BEATS{1'b0}};
        for (int k = 0; k < BEATS; k++) begin
            if (k <= int'(cnt_r)) begin
                keep_s[k] = 1'b1;
            end else begin
                keep_s[k] = 1'b0;
            end
        end
    end

    // Keep register tracks out_reg loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keep_r <= {BEATS{1'b0}};
        end else if (load_s) begin
            keep_r <= keep_s;
        end
    end

    assign down_keep = keep_r;
`endif

    assign down_data  = out_reg_r;
    assign down_valid = out_vld_r;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the byte stream.
module tb_byte_packer;

    localparam int BEATS = 4;
    localparam int OUT_W = 8 * BEATS;
`ifdef BYTE_PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       up_data;
    logic             up_valid;
    logic             up_ready;
    logic [OUT_W-1:0] down_data;
    logic             down_valid;
    logic             down_ready;
`ifdef BYTE_PACKER_FLUSH_EN
    logic             up_last;
    logic [BEATS-1:0] down_keep;
    logic [BEATS-1:0] exp_keep;
`endif

    logic [7:0]       pend[$];
    logic             exp_vld;
    logic [OUT_W-1:0] exp_word;
    bit               last_acc;
    int               n_checks = 0;
    int               n_fail   = 0;

    byte_packer #(.BEATS(BEATS)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
`ifdef BYTE_PACKER_FLUSH_EN
        .up_last    (up_last),
        .down_keep  (down_keep),
`endif
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] pack_pend();
        logic [OUT_W-1:0] w;
        w = {OUT_W{1'b0}};
        for (int i = 0; i < pend.size(); i++) w[8*i +: 8] = pend[i];
        return w;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_vld  = 1'b0;
        exp_word = {OUT_W{1'b0}};
`ifdef BYTE_PACKER_FLUSH_EN
        exp_keep = {BEATS{1'b0}};
`endif
    endtask

    // One clock: drive at negedge, compare just after, then advance the model at posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic dr, input logic lst);
        bit is_last, is_final, rdy, took;
        @(negedge clk);
        up_valid   = v;
        up_data    = d;
        down_ready = dr;
`ifdef BYTE_PACKER_FLUSH_EN
        up_last    = lst;
`endif
        is_last  = FLUSH && lst;
        is_final = (pend.size() == BEATS - 1) || is_last;
        rdy      = !(is_final && exp_vld && !dr);
        #1;
        chk("up_ready", {63'd0, up_ready}, {63'd0, rdy});
        chk("down_valid", {63'd0, down_valid}, {63'd0, exp_vld});
        chk("down_data", 64'(down_data), 64'(exp_word));
`ifdef BYTE_PACKER_FLUSH_EN
        chk("down_keep", 64'(down_keep), 64'(exp_keep));
`endif
        @(posedge clk);
        took     = v && rdy;
        last_acc = took;
        if (took) pend.push_back(d);
        if (took && is_final) begin
            exp_word = pack_pend();
`ifdef BYTE_PACKER_FLUSH_EN
            exp_keep = {BEATS{1'b0}};
            for (int i = 0; i < pend.size(); i++) exp_keep[i] = 1'b1;
`endif
            exp_vld = 1'b1;
            pend.delete();
        end else if (exp_vld && dr) begin
            exp_vld = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic dr, input logic lst);
        int tries = 0;
        do begin
            step(1'b1, d, dr, lst);
            tries++;
        end while (!last_acc && tries < 16);
        chk("push_accepted", {63'd0, last_acc}, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        up_valid   = 1'b0;
        down_ready = 1'b1;
        #1;
        chk("rst_valid", {63'd0, down_valid}, 64'd0);
        chk("rst_data", 64'(down_data), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_valid_hold", {63'd0, down_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = 8'h00;
        down_ready = 1'b1;
`ifdef BYTE_PACKER_FLUSH_EN
        up_last    = 1'b0;
`endif
        model_reset();
        do_reset();

        // Basic word: 11,22,33,44 -> 0x44332211 for exactly one cycle.
        push(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b1, 1'b0);
        push(8'h33, 1'b1, 1'b0);
        push(8'h44, 1'b1, 1'b0);
        #1;
        chk("t1_valid", {63'd0, down_valid}, 64'd1);
        chk("t1_data", 64'(down_data), 64'h44332211);
        step(1'b0, 8'($urandom), 1'b1, 1'b0);
        #1;
        chk("t1_one_cycle", {63'd0, down_valid}, 64'd0);

        // Back-to-back words with no bubble at the boundary.
        for (int i = 1; i <= 8; i++) begin
            push(8'(i), 1'b1, 1'b0);
            chk("t2_took_first_try", {63'd0, last_acc}, 64'd1);
            if (i == 4) begin
                #1;
                chk("t2_w1", 64'(down_data), 64'h04030201);
            end
        end
        #1;
        chk("t2_w2", 64'(down_data), 64'h08070605);
        chk("t2_w2_valid", {63'd0, down_valid}, 64'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure: three bytes absorbed, fourth stalls, word held until drain.
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b1, 1'b0);
        push(8'h05, 1'b0, 1'b0);
        push(8'h06, 1'b0, 1'b0);
        push(8'h07, 1'b0, 1'b0);
        step(1'b1, 8'h08, 1'b0, 1'b0);
        chk("t3_stalled", {63'd0, last_acc}, 64'd0);
        step(1'b1, 8'h08, 1'b0, 1'b0);
        #1;
        chk("t3_bp_ready", {63'd0, up_ready}, 64'd0);
        chk("t3_hold", 64'(down_data), 64'h04030201);
        push(8'h08, 1'b1, 1'b0);
        #1;
        chk("t3_w2_valid", {63'd0, down_valid}, 64'd1);
        chk("t3_w2", 64'(down_data), 64'h08070605);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-word discards partial bytes.
        push(8'hAA, 1'b1, 1'b0);
        push(8'hBB, 1'b1, 1'b0);
        do_reset();
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b1, 1'b0);
        #1;
        chk("t4_data", 64'(down_data), 64'h04030201);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Toggling up_valid with junk on idle cycles.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h51 + i), 1'b1, 1'b0);
            if (i == 3) begin
                #1;
                chk("t5_w1", 64'(down_data), 64'h54535251);
            end
            if (i == 7) begin
                #1;
                chk("t5_w2", 64'(down_data), 64'h58575655);
            end
            step(1'b0, 8'($urandom), 1'b1, 1'b0);
        end

`ifdef BYTE_PACKER_FLUSH_EN
        // Short word closed by up_last, then a full word.
        push(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b1, 1'b0);
        push(8'h33, 1'b1, 1'b1);
        #1;
        chk("t6_short_data", 64'(down_data), 64'h00332211);
        chk("t6_short_keep", 64'(down_keep), 64'h7);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) push(8'(8'h60 + i), 1'b1, 1'b0);
        #1;
        chk("t6_full_keep", 64'(down_keep), 64'hF);
        chk("t6_full_data", 64'(down_data), 64'h64636261);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
